// File: rtl/alu_serial16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial16_pkg
// Description : Shared op/state encodings and width default for the serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_serial16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_SLT  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_NONE = 3'b111;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [STATE_W-1:0] ST_FIX   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_serial16_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_slice
// Description : Combinational 1-bit ALU slice (AND/OR/XOR/full-add, B invert).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_slice
    import alu_serial16_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       res,
    output logic       cout
);

    logic w_b;
    logic w_sum;

    assign w_b   = b ^ binvert;
    assign w_sum = a ^ w_b ^ cin;
    assign cout  = (a & w_b) | (a & cin) | (w_b & cin);

    always_comb begin
        res = 1'b0;
        case (op)
            OP_AND:         res = a & w_b;
            OP_OR:          res = a | w_b;
            OP_XOR:         res = a ^ w_b;
            OP_ADD, OP_SLT: res = w_sum;
            default:        res = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_serial16.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial16
// Description : Bit-serial ALU, one bit per clock, start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial16
    import alu_serial16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             binvert,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [2:0]         r_op;
    logic               r_binv;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_amt;
    logic               r_cflag;
    logic               r_vflag;

    logic               w_bit;
    logic               w_cout;
    logic               w_last;
    logic               w_shift_last;
    logic [WIDTH-1:0]   w_run_res;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_final;
    logic               w_fin_c;
    logic               w_fin_v;
    logic               w_binv_eff;

    alu_serial_slice u_slice (
        .a       (r_a[0]),
        .b       (r_b[0]),
        .binvert (r_binv),
        .cin     (r_carry),
        .op      (r_op),
        .res     (w_bit),
        .cout    (w_cout)
    );

    // SLT always subtracts, regardless of the caller's binvert
    assign w_binv_eff   = binvert | (op == OP_SLT);
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_shift_last = (r_cnt == CNT_W'(r_amt - 4'd1));
    assign w_run_res    = {w_bit, r_acc[WIDTH-1:1]};
    assign w_shifted    = (r_op == OP_SLL) ? {r_acc[WIDTH-2:0], 1'b0}
                                           : {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift(op))
                        w_next = (b[3:0] == 4'd0) ? ST_DONE : ST_SHIFT;
                    else if (op == OP_NONE)
                        w_next = ST_DONE;
                    else
                        w_next = ST_RUN;
                end
            end
            ST_RUN:   if (w_last) w_next = (r_op == OP_SLT) ? ST_FIX : ST_DONE;
            ST_SHIFT: if (w_shift_last) w_next = ST_DONE;
            ST_FIX:   w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_IDLE: busy = 1'b0;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Value and flags committed to the outputs on the edge that enters DONE
    always_comb begin
        w_final = '0;
        w_fin_c = 1'b0;
        w_fin_v = 1'b0;
        case (r_state)
            ST_IDLE:  w_final = is_shift(op) ? a : '0;
            ST_RUN: begin
                w_final = w_run_res;
                if (r_op == OP_ADD) begin
                    w_fin_c = w_cout;
                    w_fin_v = r_carry ^ w_cout;
                end
            end
            ST_SHIFT: w_final = w_shifted;
            ST_FIX: begin
                w_final = {{(WIDTH-1){1'b0}}, r_acc[WIDTH-1] ^ r_vflag};
                w_fin_c = r_cflag;
                w_fin_v = r_vflag;
            end
            default:  w_final = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_op      <= OP_NONE;
            r_binv    <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_amt     <= '0;
            r_cflag   <= 1'b0;
            r_vflag   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_binv  <= w_binv_eff;
                        r_carry <= w_binv_eff;
                        r_cnt   <= '0;
                        r_amt   <= b[3:0];
                        r_acc   <= is_shift(op) ? a : '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_acc   <= w_run_res;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cflag <= w_cout;
                        r_vflag <= r_carry ^ w_cout;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_shifted;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (w_next == ST_DONE) begin
                result    <= w_final;
                carry_out <= w_fin_c;
                overflow  <= w_fin_v;
                zero      <= (w_final == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial16.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial16
// Description : Self-checking bench: directed vector table plus random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        binvert;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] held_res = 16'h0000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        binv;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          lat;
    } vec_t;

    alu_serial16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .binvert   (binvert),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic [2:0] mop,
                         input logic mbinv, output vec_t v);
        logic [15:0]        bb;
        logic [16:0]        s;
        logic signed [15:0] sa;
        int                 k;
        v.a = ma; v.b = mb; v.op = mop; v.binv = mbinv;
        v.c = 1'b0; v.v = 1'b0; v.res = 16'h0; v.lat = 17;
        bb  = mbinv ? ~mb : mb;
        sa  = ma;
        k   = int'(mb[3:0]);
        case (mop)
            3'b000: v.res = ma & bb;
            3'b010: v.res = ma | bb;
            3'b011: v.res = ma ^ bb;
            3'b100: begin
                s     = {1'b0, ma} + {1'b0, bb} + {16'h0, mbinv};
                v.res = s[15:0];
                v.c   = s[16];
                v.v   = (ma[15] == bb[15]) && (s[15] != ma[15]);
            end
            3'b001: begin
                s     = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
                v.c   = s[16];
                v.v   = (ma[15] != mb[15]) && (s[15] != ma[15]);
                v.res = ($signed(ma) < $signed(mb)) ? 16'h0001 : 16'h0000;
                v.lat = 18;
            end
            3'b101: begin v.res = ma << k; v.lat = k + 1; end
            3'b110: begin v.res = sa >>> k; v.lat = k + 1; end
            default: begin v.res = 16'h0; v.lat = 1; end
        endcase
        v.z = (v.res == 16'h0);
    endtask

    task automatic run_op(input vec_t v, input bit hold, input string tag);
        int cyc;
        bit got;
        bit busy_ok;
        bit held_ok;
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; binvert = v.binv; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        cyc = 1; got = 0; busy_ok = 1; held_ok = 1;
        while (cyc <= 40) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (result !== held_res) held_ok = 0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, got ? cyc : 0, v.lat);
        if (got) begin
            chk({tag, " busy@done"}, busy, 1'b1);
            chk({tag, " result"}, result, v.res);
            chk({tag, " carry_out"}, carry_out, v.c);
            chk({tag, " overflow"}, overflow, v.v);
            chk({tag, " zero"}, zero, v.z);
        end
        chk({tag, " busy while running"}, busy_ok, 1'b1);
        chk({tag, " result held while running"}, held_ok, 1'b1);
        held_res = v.res;
        @(posedge clk); #1;
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle done"}, done, 1'b0);
        chk({tag, " idle result held"}, result, v.res);
    endtask

    initial begin
        vec_t vecs[12];
        vec_t rv;
        bit   saw_done;

        vecs[0]  = '{16'h1234, 16'h0FFF, 3'b100, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 17};
        vecs[1]  = '{16'h8000, 16'h0001, 3'b100, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 17};
        vecs[2]  = '{16'h5A5A, 16'h5A5A, 3'b100, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 17};
        vecs[3]  = '{16'hFFFE, 16'h0003, 3'b001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 18};
        vecs[4]  = '{16'h7FFF, 16'h8000, 3'b001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 18};
        vecs[5]  = '{16'h0001, 16'h0004, 3'b101, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 5};
        vecs[6]  = '{16'h8000, 16'h000F, 3'b110, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16};
        vecs[7]  = '{16'h1234, 16'h0000, 3'b101, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{16'hABCD, 16'h1234, 3'b111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[9]  = '{16'h00F0, 16'h0F00, 3'b010, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 17};
        vecs[10] = '{16'hFFFF, 16'h00FF, 3'b011, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b0, 17};
        vecs[11] = '{16'hFFFF, 16'h0001, 3'b100, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 17};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0; binvert = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 16'h0);
        chk("reset zero", zero, 1'b0);
        chk("reset carry_out", carry_out, 1'b0);
        chk("reset overflow", overflow, 1'b0);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // start held high through an AND must not be re-accepted while busy
        rv = '{16'hF0F0, 16'hFF00, 3'b000, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0, 17};
        run_op(rv, 1'b1, "hold_and");
        start = 1'b0;

        // reset mid-ADD at cycle 8
        model(16'h1234, 16'h0FFF, 3'b100, 1'b0, rv);
        run_op(rv, 1'b0, "pre_reset");
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; op = 3'b100; binvert = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset result", result, 16'h0);
        chk("midreset zero", zero, 1'b0);
        saw_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        chk("midreset no done pulse", saw_done, 1'b0);
        held_res = 16'h0;
        model(16'h1111, 16'h2222, 3'b100, 1'b0, rv);
        run_op(rv, 1'b0, "post_reset_add");

        for (int i = 0; i < 40; i++) begin
            model(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), rv);
            run_op(rv, 1'b0, $sformatf("rand%0d op%0d", i, rv.op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial16.md
# alu_serial16

Bit-serial 16-bit ALU for area-constrained builds of the single-cycle processor datapath. It uses the same 3-bit operation encoding and BInvert/carry-in convention as the parallel 16-bit ALU, but processes one bit per clock through a single 1-bit slice. Carry and partial result live in registers between cycles. A start/busy/done handshake lets the control unit stall while the operation runs.

## Interface
- `WIDTH`, default 16: operand/result width; counter width is clog2(WIDTH).
- `clk`, input, 1: single clock; everything is rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request an operation; sampled only in IDLE.
- `a`, input, WIDTH: operand A; latched on the accepted start.
- `b`, input, WIDTH: operand B, or shift amount in `b[3:0]`; latched on the accepted start.
- `op`, input, 3: operation select.
  - 000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD/SUB.
  - 101 SLL, 110 SRA, 111 unused.
- `binvert`, input, 1: invert B and force carry-in to 1 (subtract); latched on the accepted start.
- `busy`, output, 1: high from the cycle after the accepted start until `done`.
- `done`, output, 1: one-cycle pulse when `result` is valid.
- `result`, output, WIDTH: final value; held until the next accepted start.
- `carry_out`, output, 1: carry out of the MSB (ADD/SUB/SLT); 0 for other ops.
- `overflow`, output, 1: two's-complement overflow (ADD/SUB/SLT); 0 for other ops.
- `zero`, output, 1: `result == 0`; valid with `done`, held afterwards.

## Operation
- States: IDLE, RUN, SHIFT, FIX, DONE.
- IDLE + `start`:
  - Latch `a`, `b`, `op`, `binvert`.
  - Set carry register to `binvert`, bit counter to 0, result shift register to 0.
- Next state depends on `op`:
  - RUN for op 000–100.
  - SHIFT for op 101/110, unless `b[3:0]`==0.
  - DONE for op 111, or for a shift with amount 0.
- RUN, LSB first:
  - Each cycle, feed bit i of A, bit i of B (inverted if `binvert`) and the carry register into the slice.
  - Shift the slice output into `result[i]` and register the new carry.
  - Counter increments. After bit WIDTH-1, go to DONE; for SLT, go to FIX instead.
- Overflow: carry into the MSB XOR carry out of the MSB, captured during the bit WIDTH-1 cycle.
- SLT:
  - RUN computes A + ~B + 1 whatever `binvert` is; SLT forces subtraction.
  - FIX writes `result = {0…0, sum[MSB] ^ overflow}`, then goes to DONE.
- SHIFT:
  - Shift amount is `b[3:0]`; the result register is loaded with A on entry.
  - Each cycle shifts by one: SLL fills 0 at the LSB; SRA replicates the MSB.
  - After amount cycles, go to DONE.
- DONE: pulse `done` for one cycle, compute `zero`, return to IDLE.
- `start` outside IDLE is ignored; no queueing.
- Reset at any point, mid-operation included:
  - State goes to IDLE; the in-flight op is discarded.
  - `result`, `carry_out`, `overflow`, `zero`, `busy`, `done` all go to 0.
  - `zero` resets to 0 even though `result` is 0.

## Timing
- Start accepted at edge 0.
- ADD/SUB/AND/OR/XOR: `done` high in cycle 17 (WIDTH+1).
- SLT: `done` in cycle 18.
- SLL/SRA by k: `done` in cycle k+1; k=0 and op 111 give `done` in cycle 1.
- `busy` is high in cycles 1 through the `done` cycle inclusive; `busy` is low in IDLE.
- `start` may be reasserted in the cycle after `done`: back-to-back ops, no bubble beyond the IDLE cycle.
- `result`, `zero` and the flags change only on the `done` cycle, or on reset.

## Structure
- Shared package/header holds:
  - Op encoding constants: OP_AND, OP_SLT, OP_OR, OP_XOR, OP_ADD, OP_SLL, OP_SRA, OP_NONE.
  - State encoding constants.
  - WIDTH default.
- One sub-module, `alu_serial_slice`: combinational 1-bit AND/OR/XOR/full-add with B inversion, selected by `op`, producing the result bit and carry.
- The FSM, counter, operand shift registers and flag logic stay in the top module.

## Test plan
- ADD: a=0x1234, b=0x0FFF, binvert=0 -> `done` at cycle 17, result=0x2233, carry_out=0, overflow=0, zero=0.
- SUB overflow: a=0x8000, b=0x0001, binvert=1 -> result=0x7FFF, overflow=1, carry_out=1; then a=b=0x5A5A sub -> result=0, zero=1.
- SLT: a=0xFFFE (-2), b=0x0003 -> `done` at cycle 18, result=0x0001; a=0x7FFF, b=0x8000 -> result=0x0000 (overflow-corrected).
- Shifts: SLL a=0x0001, b=4 -> `done` cycle 5, result=0x0010. SRA a=0x8000, b=15 -> result=0xFFFF. SLL b=0 -> `done` cycle 1, result=a.
- Handshake: `start` held high through an AND (a=0xF0F0, b=0xFF00 -> 0xF000) is not re-accepted while `busy`. A new op starts in the cycle after `done`. op=111 -> result=0, `done` cycle 1.
- Reset at cycle 8 of an ADD -> next cycle IDLE, `busy`=0, result=0, no `done` pulse; a fresh ADD then completes normally.
